// File: rtl/serial_delay_arbiter_pkg.sv
// Shared types and helpers for serial_delay_arbiter.
//   state_e : transaction FSM encoding (IDLE -> RUN -> RESP -> IDLE)
//   clog2   : ceil(log2(v)), never less than 1, usable for port widths
package serial_delay_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_delay_arbiter_rr_arbiter.sv
// Round-robin pick of one requester.
//   i_req    : request vector
//   i_ptr    : last winner; search starts at i_ptr+1 and wraps
//   o_onehot : one-hot winner (all zero when no request)
//   o_idx    : winner index
//   o_any    : at least one request present
module rr_arbiter
  import serial_delay_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    // k = N_REQ lands back on i_ptr, so the previous winner is considered last.
    for (int k = 1; k <= N_REQ; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % N_REQ]) begin
        o_any                                 = 1'b1;
        o_idx                                 = IW'((int'(i_ptr) + k) % N_REQ);
        o_onehot[(int'(i_ptr) + k) % N_REQ]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_delay_arbiter.sv
// Shares one 1-bit delay line among N_REQ requesters. A round-robin winner's
// word is shifted LSB-first into the line, recaptured LINE_LAT cycles later
// from the line output, and returned tagged with the requester id.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_req, i_word_in   : per-requester request and word (slice i at i*WORD_W)
//   o_gnt              : registered one-hot acceptance pulse
//   o_line_din         : serial bit into the delay line
//   i_line_dout        : serial bit out of the delay line
//   o_resp_valid       : 1-cycle pulse qualifying o_resp_id / o_resp_word
//   o_resp_id          : requester owning o_resp_word (held)
//   o_resp_word        : recovered word (held)
//   o_busy             : a transaction is in flight
module serial_delay_arbiter
  import serial_delay_arbiter_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int WORD_W   = 8,
  parameter  int LINE_LAT = 32,
  localparam int IW       = clog2(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*WORD_W-1:0]   i_word_in,
  output logic [N_REQ-1:0]          o_gnt,
  output logic                      o_line_din,
  input  logic                      i_line_dout,
  output logic                      o_resp_valid,
  output logic [IW-1:0]             o_resp_id,
  output logic [WORD_W-1:0]         o_resp_word,
  output logic                      o_busy
);

  localparam int            CW       = clog2(LINE_LAT + WORD_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LINE_LAT + WORD_W - 1);

  state_e              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [WORD_W-1:0]   r_shreg;
  logic [WORD_W-1:0]   r_rword;
  logic [WORD_W-1:0]   w_rword_cap;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_resp_id_nxt;
  logic [N_REQ-1:0]    r_gnt;
  logic                r_resp_valid;
  logic [IW-1:0]       r_resp_id;
  logic [WORD_W-1:0]   r_resp_word;

  logic [N_REQ-1:0]    w_win_onehot;
  logic [IW-1:0]       w_win_idx;
  logic                w_win_any;
  logic                w_last;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req    (i_req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_any    (w_win_any)
  );

  assign w_last = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

  // Bit b of the word comes back on the line at cnt = LINE_LAT + b.
  always_comb begin
    w_rword_cap = r_rword;
    for (int b = 0; b < WORD_W; b++) begin
      if (r_cnt == CW'(LINE_LAT + b)) w_rword_cap[b] = i_line_dout;
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_win_any) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_RESP;
      ST_RESP:                w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. The line is driven with zeros outside the word window so
  // stale bits never reach a later capture window.
  always_comb begin
    o_busy     = (r_state != ST_IDLE);
    o_line_din = 1'b0;
    if (r_state == ST_RUN && r_cnt < CW'(WORD_W)) o_line_din = r_shreg[0];
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_shreg       <= '0;
      r_rword       <= '0;
      r_rr_ptr      <= IW'(N_REQ - 1);
      r_resp_id_nxt <= '0;
      r_gnt         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_word   <= '0;
    end else begin
      r_gnt        <= '0;
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_shreg       <= i_word_in[w_win_idx*WORD_W +: WORD_W];
            r_resp_id_nxt <= w_win_idx;
            r_rr_ptr      <= w_win_idx;
            r_gnt         <= w_win_onehot;
            r_cnt         <= '0;
          end
        end
        ST_RUN: begin
          r_shreg <= r_shreg >> 1;
          r_rword <= w_rword_cap;
          if (w_last) begin
            // Response registers load on the last capture edge so that
            // id/word are already valid during the RESP pulse.
            r_resp_valid <= 1'b1;
            r_resp_word  <= w_rword_cap;
            r_resp_id    <= r_resp_id_nxt;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_id    = r_resp_id;
  assign o_resp_word  = r_resp_word;

endmodule

// File: tb/tb_serial_delay_arbiter.sv
module tb_serial_delay_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  word_in = '0;
  logic [N-1:0]    gnt;
  logic            line_din;
  logic            line_dout;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [W-1:0]    resp_word;
  logic            busy;
  logic [L-1:0]    dl;

  always #5 clk = ~clk;

  serial_delay_arbiter #(.N_REQ(N), .WORD_W(W), .LINE_LAT(L)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_word_in    (word_in),
    .o_gnt        (gnt),
    .o_line_din   (line_din),
    .i_line_dout  (line_dout),
    .o_resp_valid (resp_valid),
    .o_resp_id    (resp_id),
    .o_resp_word  (resp_word),
    .o_busy       (busy)
  );

  // Delay line model: depth L, active-high reset tied to ~rst_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dl <= '0;
    else        dl <= {dl[L-2:0], line_din};
  end
  assign line_dout = dl[L-1];

  typedef struct packed { logic [1:0] id; logic [7:0] word; } resp_t;
  resp_t exp_resp_q[$];
  int    exp_gnt_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    gnt_cyc = -1000;
  bit    chk_space = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (|gnt) begin
        if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
        else begin
          int e;
          e = exp_gnt_q.pop_front();
          chk("gnt", 32'(gnt), 32'(1 << e));
        end
        if (chk_space) chk("gnt_spacing", cyc - gnt_cyc, 42);
        gnt_cyc = cyc;
      end
      if (resp_valid) begin
        if (exp_resp_q.size() == 0) chk("resp_unexpected", 32'(resp_valid), 0);
        else begin
          resp_t r;
          r = exp_resp_q.pop_front();
          chk("resp_id", 32'(resp_id), 32'(r.id));
          chk("resp_word", 32'(resp_word), 32'(r.word));
        end
        chk("resp_latency", cyc - gnt_cyc, 40);
      end
    end
  end

  // Wait for n grants; requesters not in hold drop req in their gnt cycle.
  task automatic wait_gnt(input int n, input logic [N-1:0] hold);
    int got;
    got = 0;
    for (int c = 0; c < 500 && got < n; c++) begin
      @(negedge clk); #1;
      if (|gnt) begin
        got++;
        req = req & ~(gnt & ~hold);
      end
    end
    if (got < n) chk("gnt_timeout", got, n);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk); #1;
      if (exp_resp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk("drain_pending", exp_resp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;

    // Reset state
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_word", 32'(resp_word), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_line_din", 32'(line_din), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset in the gnt cycle of an FF word
    exp_gnt_q.push_back(0);
    word_in[7:0] = 8'hFF;
    req[0] = 1'b1;
    wait_gnt(1, '0);
    chk("pre_abort_line_din", 32'(line_din), 1);
    #($urandom_range(1, 2));
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 0);
    chk("async_resp_valid", 32'(resp_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_line_din", 32'(line_din), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2: single A5 transfer, serial pattern on the line
    exp_gnt_q.push_back(0);
    exp_resp_q.push_back('{id: 2'd0, word: 8'hA5});
    word_in[7:0] = 8'hA5;
    req[0] = 1'b1;
    wait_gnt(1, '0);
    pat = 8'hA5;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("line_din_bit%0d", i), 32'(line_din), 32'(pat[i]));
      @(negedge clk); #1;
    end
    chk("line_din_after_word", 32'(line_din), 0);
    drain();

    // 3: all four requesting from reset, 42-cycle grant spacing
    do_reset();
    for (int i = 0; i < N; i++) exp_gnt_q.push_back(i);
    exp_resp_q.push_back('{id: 2'd0, word: 8'h11});
    exp_resp_q.push_back('{id: 2'd1, word: 8'h22});
    exp_resp_q.push_back('{id: 2'd2, word: 8'h33});
    exp_resp_q.push_back('{id: 2'd3, word: 8'h44});
    word_in = 32'h44332211;
    req = 4'b1111;
    wait_gnt(1, '0);
    chk_space = 1'b1;
    wait_gnt(3, '0);
    drain();
    chk_space = 1'b0;

    // 4: req0 and req2 held permanently -> 0,2,0,2
    word_in = {8'h00, 8'hC3, 8'h00, 8'h5A};
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(2);
    exp_resp_q.push_back('{id: 2'd0, word: 8'h5A});
    exp_resp_q.push_back('{id: 2'd2, word: 8'hC3});
    exp_resp_q.push_back('{id: 2'd0, word: 8'h5A});
    exp_resp_q.push_back('{id: 2'd2, word: 8'hC3});
    req = 4'b0101;
    wait_gnt(4, 4'b0101);
    req = '0;
    drain();

    // 5: reset at cnt=20 of req1, then a clean 3C transfer
    do_reset();
    exp_gnt_q.push_back(1);
    word_in[15:8] = 8'hE7;
    req[1] = 1'b1;
    wait_gnt(1, '0);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_gnt_q.push_back(1);
    exp_resp_q.push_back('{id: 2'd1, word: 8'h3C});
    word_in[15:8] = 8'h3C;
    req[1] = 1'b1;
    wait_gnt(1, '0);
    drain();

    // 6: req3 raised mid-RUN, word changed twice before its grant
    exp_gnt_q.push_back(1);
    exp_resp_q.push_back('{id: 2'd1, word: 8'h77});
    word_in[15:8] = 8'h77;
    req[1] = 1'b1;
    wait_gnt(1, '0);
    repeat (5) @(negedge clk);
    exp_gnt_q.push_back(3);
    exp_resp_q.push_back('{id: 2'd3, word: 8'h81});
    word_in[31:24] = 8'h01;
    req[3] = 1'b1;
    repeat (10) @(negedge clk);
    word_in[31:24] = 8'h02;
    repeat (10) @(negedge clk);
    word_in[31:24] = 8'h81;
    wait_gnt(1, '0);
    word_in[31:24] = 8'hFF;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
